// File: rtl/bus_arbiter.sv
// Two-master (CPU/DMA) shared-bus arbiter with round-robin tie break
// and a per-transaction WAIT timeout that aborts with bus_err.
module bus_arbiter #(
   parameter logic [7:0] TIMEOUT = 8'd200
) (
   input  logic clk,
   input  logic reset,
   input  logic cpu_req,
   input  logic dma_req,
   input  logic bus_ack,
   output logic cpu_grant,
   output logic dma_grant,
   output logic bus_start,
   output logic bus_owner,
   output logic cpu_done,
   output logic dma_done,
   output logic bus_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      START   = 2'd1,
      WAIT    = 2'd2,
      RELEASE = 2'd3
   } state_e;

   state_e     state_q;
   logic       owner_q;
   logic [7:0] timer_q;
   logic [7:0] timer_d;
   logic       err_q;
   logic       cpu_grant_q;
   logic       dma_grant_q;
   logic       bus_start_q;
   logic       cpu_done_q;
   logic       dma_done_q;
   logic       bus_err_q;
   logic       win_dma;
   logic       tmo_hit;

   // DMA wins when alone, or on a tie when the CPU owned the bus last
   assign win_dma = dma_req & (~cpu_req | ~owner_q);
   assign tmo_hit = (timer_q == 8'(TIMEOUT - 8'd1));
   assign timer_d = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b1;
         timer_q     <= 8'd0;
         err_q       <= 1'b0;
         cpu_grant_q <= 1'b0;
         dma_grant_q <= 1'b0;
         bus_start_q <= 1'b0;
         cpu_done_q  <= 1'b0;
         dma_done_q  <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         bus_start_q <= 1'b0;
         cpu_done_q  <= 1'b0;
         dma_done_q  <= 1'b0;
         bus_err_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (cpu_req | dma_req) begin
                  state_q     <= START;
                  owner_q     <= win_dma;
                  cpu_grant_q <= ~win_dma;
                  dma_grant_q <= win_dma;
                  bus_start_q <= 1'b1;
                  timer_q     <= 8'd0;
                  err_q       <= 1'b0;
               end
            end
            START: begin
               state_q <= WAIT;
               timer_q <= 8'd0;
            end
            WAIT: begin
               timer_q <= timer_d;
               // ack takes priority over a coincident timeout
               if (bus_ack | tmo_hit) begin
                  state_q     <= RELEASE;
                  err_q       <= ~bus_ack;
                  bus_err_q   <= ~bus_ack;
                  cpu_grant_q <= 1'b0;
                  dma_grant_q <= 1'b0;
                  cpu_done_q  <= ~owner_q;
                  dma_done_q  <= owner_q;
               end
            end
            RELEASE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign cpu_grant = cpu_grant_q;
   assign dma_grant = dma_grant_q;
   assign bus_start = bus_start_q;
   assign bus_owner = owner_q;
   assign cpu_done  = cpu_done_q;
   assign dma_done  = dma_done_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (TIMEOUT = 5).
// Output vector order: cpu_grant dma_grant bus_start bus_owner cpu_done dma_done bus_err
module tb_bus_arbiter;

   logic clk = 1'b0;
   logic reset;
   logic cpu_req;
   logic dma_req;
   logic bus_ack;
   logic cpu_grant;
   logic dma_grant;
   logic bus_start;
   logic bus_owner;
   logic cpu_done;
   logic dma_done;
   logic bus_err;

   int n_chk  = 0;
   int n_fail = 0;

   bus_arbiter #(.TIMEOUT(8'd5)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .dma_req   (dma_req),
      .bus_ack   (bus_ack),
      .cpu_grant (cpu_grant),
      .dma_grant (dma_grant),
      .bus_start (bus_start),
      .bus_owner (bus_owner),
      .cpu_done  (cpu_done),
      .dma_done  (dma_done),
      .bus_err   (bus_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [6:0] exp);
      logic [6:0] obs;
      obs = {cpu_grant, dma_grant, bus_start, bus_owner,
             cpu_done, dma_done, bus_err};
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      reset   = 1'b1;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      bus_ack = 1'b0;
      tick();
      tick();
      chk("in_reset", 7'b0001000);
      reset = 1'b0;
      tick();
      chk("idle_noreq", 7'b0001000);

      // single CPU, ack in first WAIT cycle
      cpu_req = 1'b1;
      tick(); chk("cpu_start", 7'b1010000);
      tick(); chk("cpu_wait", 7'b1000000);
      bus_ack = 1'b1;
      tick(); chk("cpu_release", 7'b0000100);
      cpu_req = 1'b0;
      bus_ack = 1'b0;
      tick(); chk("cpu_idle", 7'b0000000);

      // tie from reset alternates CPU, DMA, CPU, DMA
      #2 reset = 1'b1;
      #1 reset = 1'b0;
      chk("reset2", 7'b0001000);
      cpu_req = 1'b1;
      dma_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic d;
         d = (i % 2) == 1;
         tick(); chk("tie_start", {~d, d, 1'b1, d, 3'b000});
         tick(); chk("tie_wait", {~d, d, 1'b0, d, 3'b000});
         bus_ack = 1'b1;
         tick(); chk("tie_release", {3'b000, d, ~d, d, 1'b0});
         bus_ack = 1'b0;
         tick(); chk("tie_idle", {3'b000, d, 3'b000});
      end
      cpu_req = 1'b0;
      dma_req = 1'b0;

      // DMA timeout: five WAIT cycles then done with error
      dma_req = 1'b1;
      tick(); chk("tmo_start", 7'b0111000);
      for (int i = 0; i < 5; i++) begin
         tick(); chk("tmo_wait", 7'b0101000);
      end
      tick(); chk("tmo_release", 7'b0001011);
      dma_req = 1'b0;
      tick(); chk("tmo_idle", 7'b0001000);

      // ack on the fifth WAIT cycle beats the timeout
      dma_req = 1'b1;
      tick(); chk("lim_start", 7'b0111000);
      for (int i = 0; i < 5; i++) begin
         tick(); chk("lim_wait", 7'b0101000);
      end
      bus_ack = 1'b1;
      tick(); chk("lim_release", 7'b0001010);
      bus_ack = 1'b0;
      dma_req = 1'b0;
      tick(); chk("lim_idle", 7'b0001000);

      // CPU drops req in START/WAIT, stray ack in IDLE
      cpu_req = 1'b1;
      tick(); chk("drop_start", 7'b1010000);
      cpu_req = 1'b0;
      tick(); chk("drop_wait1", 7'b1000000);
      tick(); chk("drop_wait2", 7'b1000000);
      bus_ack = 1'b1;
      tick(); chk("drop_release", 7'b0000100);
      tick(); chk("stray_idle1", 7'b0000000);
      tick(); chk("stray_idle2", 7'b0000000);
      bus_ack = 1'b0;

      // async reset mid-WAIT, then CPU wins the tie
      cpu_req = 1'b1;
      dma_req = 1'b1;
      tick(); chk("rst_start", 7'b0111000);
      tick(); chk("rst_wait", 7'b0101000);
      #2 reset = 1'b1;
      #1 chk("rst_async", 7'b0001000);
      #1 reset = 1'b0;
      tick(); chk("rst_tie_cpu", 7'b1010000);
      tick(); chk("rst_tie_wait", 7'b1000000);
      bus_ack = 1'b1;
      tick(); chk("rst_tie_rel", 7'b0000100);
      bus_ack = 1'b0;
      cpu_req = 1'b0;
      dma_req = 1'b0;
      tick(); chk("rst_tie_idle", 7'b0000000);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
